mux2to1_arbiter: RTL and testbench
==================================

Name: mux2to1_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit 2:1 mux datapath between two requesters, A and B.
- Each requester presents a 4-bit word and a request. The block grants ownership, drives the mux select, and delivers the selected word as a registered output with a valid flag.
- Grant tenure is bounded, so one requester cannot starve the other.
- Sits between switch/key-driven sources and the LEDR/HEX consumers of the top-level design.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits. Legal range 1..15.
- DATA_W, 4, data width. Fixed to 4 to match the mux datapath; other values unsupported.

Ports:
- CLOCK_50  input  1  system clock. All logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  requester A wants the datapath.
- req_b  input  1  requester B wants the datapath.
- data_a  input  4  requester A word (mux X input).
- data_b  input  4  requester B word (mux Y input).
- gnt_a  output  1  A owns the datapath this cycle.
- gnt_b  output  1  B owns the datapath this cycle.
- sel  output  1  mux select: 0 = A, 1 = B. Holds its last value when idle.
- out_data  output  4  registered mux output.
- out_valid  output  1  out_data is valid.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high.
- Reset values: gnt_a = 0, gnt_b = 0, sel = 0, out_data = 0, out_valid = 0. Internal state: state = IDLE, hold_cnt = 0, last_owner = B, so A wins the first tie.
- State register: IDLE, OWN_A, OWN_B. gnt_a = (state == OWN_A) and gnt_b = (state == OWN_B), both decoded from the register. sel is registered and updated on every entry to OWN_A or OWN_B.
- Grant latency: a request sampled at edge N gives a grant visible after edge N (one cycle). Data latency: out_data after edge N+1 equals data_x sampled at edge N+1. out_valid follows the grant with one cycle of delay.
- From IDLE:
  - Only req_a: go to OWN_A.
  - Only req_b: go to OWN_B.
  - Both: go to the requester that is not last_owner.
  - Neither: stay in IDLE.
- From OWN_x, evaluated each edge:
  - req_x = 0: release. Go to OWN_y if req_y, else IDLE.
  - req_x = 1, req_y = 1, hold_cnt == MAX_HOLD-1: forced turnover to OWN_y.
  - Otherwise stay in OWN_x. hold_cnt increments and saturates at MAX_HOLD-1.
- hold_cnt clears to 0 on every state change. last_owner updates whenever OWN_x is exited.
- Direct A-to-B handover has no idle bubble. sel changes on the same edge as the grant.
- out_valid = 1 exactly one cycle after any cycle with gnt_a or gnt_b asserted. When out_valid = 0, out_data holds its last value.
- Sole requester: keeps the grant indefinitely. The hold limit applies only while the other requester is requesting.
- MAX_HOLD = 1: strict alternation under continuous dual request.
- Reset asserted mid-grant: on that edge everything returns to reset values, including out_valid = 0, regardless of requests.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While the current owner holds lock = 1, forced turnover is suppressed and hold_cnt stays saturated. Release still occurs on deassertion of req_x. lock is ignored in IDLE.
- Undefined: no lock port; the hold limit is always enforced.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state enum (IDLE, OWN_A, OWN_B)
  - DATA_W constant
  - default MAX_HOLD
  - SEL_A = 0, SEL_B = 1
- One sub-module is natural: fourBit_mux2to1, the existing 4-bit datapath. It is instantiated with X = data_a, Y = data_b, S = sel, and its Z output is registered into out_data.
- The state machine and hold counter stay in the top module.

Test Plan:
- Reset, then req_a = 1 and data_a = 4'hA for 3 cycles -> gnt_a high from cycle 1, sel = 0, out_valid high from cycle 2, out_data = 4'hA.
- req_a and req_b both asserted in the first cycle after reset, held continuously, MAX_HOLD = 4 -> A is granted for 4 cycles, then B for 4, then A. No idle cycles; gnt_a and gnt_b are never high together.
- A owns the datapath and drops req_a at cycle 5 while req_b = 1 and data_b = 4'h5 -> gnt_b at cycle 6, sel = 1, out_data = 4'h5 at cycle 7.
- Only req_b held for 20 cycles -> gnt_b stays high throughout and hold_cnt saturates without turnover.
- Reset asserted during OWN_B -> next cycle all outputs are 0 and state is IDLE. Simultaneous requests afterwards are granted to A first.
- With MUX_ARB_LOCK_EN defined, A holds lock = 1 with both requesting -> A keeps the grant beyond MAX_HOLD. Dropping lock -> turnover to B on the next edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int DATA_W       = 4;
  localparam int MAX_HOLD_DEF = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // Saturating increment used by the tenure counter.
  function automatic logic [3:0] satInc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/fourBit_mux2to1.sv
// Existing 4-bit 2:1 mux datapath: Z = X when S = 0, Z = Y when S = 1.
module fourBit_mux2to1 (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       S,
  output logic [3:0] Z
);

  assign Z = S ? Y : X;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter sharing a 4-bit 2:1 mux between requesters A and B with bounded tenure.
// Optional MUX_ARB_LOCK_EN adds a 'lock' input that lets the current owner suppress forced turnover.
module mux2to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
`ifdef MUX_ARB_LOCK_EN
  input  logic              lock,
`endif
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  owner_e            last_owner_q, last_owner_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mux_z;
  logic              lock_hold;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  fourBit_mux2to1 u_mux (
    .X(data_a),
    .Y(data_b),
    .S(sel_q),
    .Z(mux_z)
  );

  // Ownership decisions; forced turnover needs a waiting peer and an expired tenure.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    sel_d        = sel_q;

    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_owner_q == OWNER_A) ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_d = OWN_A;
        end else if (req_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
        end else if (req_b && (hold_cnt_q == HOLD_LAST) && !lock_hold) begin
          state_d = OWN_B;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
        end else if (req_a && (hold_cnt_q == HOLD_LAST) && !lock_hold) begin
          state_d = OWN_A;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      hold_cnt_d = 4'd0;
      if (state_q == OWN_A) begin
        last_owner_d = OWNER_A;
      end else if (state_q == OWN_B) begin
        last_owner_d = OWNER_B;
      end
    end else if (state_q != IDLE) begin
      hold_cnt_d = satInc(hold_cnt_q, HOLD_LAST);
    end

    if (state_d == OWN_A) begin
      sel_d = SEL_A;
    end else if (state_d == OWN_B) begin
      sel_d = SEL_B;
    end
  end

  // Output register captures the mux one cycle after the grant; it holds while invalid.
  always_comb begin
    out_valid_d = (state_q != IDLE);
    out_data_d  = out_valid_d ? mux_z : out_data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 4'd0;
      last_owner_q <= OWNER_B;
      sel_q        <= SEL_A;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign gnt_a     = (state_q == OWN_A);
  assign gnt_b     = (state_q == OWN_B);
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Self-checking bench for mux2to1_arbiter against a tenure-based ownership model.
module tb_mux2to1_arbiter;
  import mux_arb_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       req_a    = 1'b0;
  logic       req_b    = 1'b0;
  logic [3:0] data_a   = 4'h0;
  logic [3:0] data_b   = 4'h0;
`ifdef MUX_ARB_LOCK_EN
  logic       lock     = 1'b0;
`endif
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [3:0] out_data;

  int errors = 0;
  int checks = 0;

  // Model: owner 0 = none, 1 = A, 2 = B; tenure = cycles the owner has held so far.
  int         mOwn    = 0;
  int         mTenure = 0;
  int         mLast   = 2;
  logic       mSel    = 1'b0;
  logic       mValid  = 1'b0;
  logic [3:0] mData   = 4'h0;

  mux2to1_arbiter #(.MAX_HOLD(MAX_HOLD_DEF)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
`ifdef MUX_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic modelEdge();
    int  nxt;
    logic lk;
    lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lk = lock;
`endif
    if (reset) begin
      mOwn = 0; mTenure = 0; mLast = 2; mSel = 1'b0; mValid = 1'b0; mData = 4'h0;
    end else begin
      mValid = (mOwn != 0);
      if (mOwn == 1) mData = data_a;
      else if (mOwn == 2) mData = data_b;
      nxt = mOwn;
      if (mOwn == 0) begin
        if (req_a && req_b) nxt = (mLast == 1) ? 2 : 1;
        else if (req_a) nxt = 1;
        else if (req_b) nxt = 2;
      end else begin
        logic mine, other;
        mine  = (mOwn == 1) ? req_a : req_b;
        other = (mOwn == 1) ? req_b : req_a;
        if (!mine) nxt = other ? 3 - mOwn : 0;
        else if (other && mTenure >= MAX_HOLD_DEF && !lk) nxt = 3 - mOwn;
      end
      if (nxt != mOwn) begin
        if (mOwn != 0) mLast = mOwn;
        mTenure = (nxt != 0) ? 1 : 0;
      end else if (mOwn != 0) begin
        mTenure++;
      end
      mOwn = nxt;
      if (mOwn != 0) mSel = (mOwn == 2);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLOCK_50);
    modelEdge();
    #1;
  endtask

  function automatic logic [7:0] expVec();
    return {mOwn == 1, mOwn == 2, mSel, mValid, mData};
  endfunction

  function automatic logic [7:0] obsVec();
    return {gnt_a, gnt_b, sel, out_valid, out_data};
  endfunction

  task automatic doReset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hC;
    stepCycle();
    stepCycle();
    checks++;
    if (obsVec() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=00", obsVec());
    end
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_single_a();
    doReset();
    req_a = 1'b1; data_a = 4'hA;
    for (int i = 1; i <= 3; i++) begin
      stepCycle();
      checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || sel !== 1'b0 || out_valid !== (i >= 2) ||
          (i >= 2 && out_data !== 4'hA)) begin
        errors++;
        $display("[TB] FAIL single_a cycle=%0d got gnt_a=%b gnt_b=%b sel=%b valid=%b data=%h",
                 i, gnt_a, gnt_b, sel, out_valid, out_data);
      end
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL single_a_model cycle=%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    req_a = 1'b0;
    stepCycle();
    stepCycle();
  endtask

  task automatic test_dual_rr();
    logic expA;
    doReset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 1; i <= 3 * MAX_HOLD_DEF; i++) begin
      data_a = 4'($urandom_range(0, 15));
      data_b = 4'($urandom_range(0, 15));
      stepCycle();
      expA = (((i - 1) / MAX_HOLD_DEF) % 2) == 0;
      checks++;
      if (gnt_a !== expA || gnt_b !== !expA || sel !== !expA) begin
        errors++;
        $display("[TB] FAIL dual_rr cycle=%0d got gnt_a=%b gnt_b=%b sel=%b want gnt_a=%b",
                 i, gnt_a, gnt_b, sel, expA);
      end
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL dual_rr_model cycle=%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    stepCycle();
  endtask

  task automatic test_release();
    doReset();
    req_a = 1'b1; data_a = 4'h9; data_b = 4'h5;
    repeat (4) stepCycle();
    req_a = 1'b0; req_b = 1'b1;
    stepCycle();
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || sel !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_grant got gnt_a=%b gnt_b=%b sel=%b want 0 1 1", gnt_a, gnt_b, sel);
    end
    stepCycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      errors++;
      $display("[TB] FAIL release_data got valid=%b data=%h want 1 5", out_valid, out_data);
    end
    req_b = 1'b0;
    stepCycle();
  endtask

  task automatic test_sole_b();
    int bad = 0;
    doReset();
    req_b = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      data_b = 4'($urandom_range(0, 15));
      stepCycle();
      if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || obsVec() !== expVec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL sole_b bad_cycles=%0d want 0", bad);
    end
    req_a = 1'b1;
    stepCycle();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sole_b_turnover got gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    stepCycle();
  endtask

  task automatic test_reset_mid();
    doReset();
    req_b = 1'b1; data_b = 4'hE;
    repeat (3) stepCycle();
    reset = 1'b1; req_a = 1'b1;
    stepCycle();
    checks++;
    if (obsVec() !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid got=%h want=00", obsVec());
    end
    reset = 1'b0;
    stepCycle();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_tie got gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    stepCycle();
  endtask

  task automatic test_random();
    int bad = 0;
    doReset();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      data_a = 4'($urandom_range(0, 15));
      data_b = 4'($urandom_range(0, 15));
`ifdef MUX_ARB_LOCK_EN
      lock   = ($urandom_range(0, 4) == 0);
`endif
      stepCycle();
      checks++;
      if (obsVec() !== expVec()) begin
        errors++; bad++;
        if (bad <= 10)
          $display("[TB] FAIL random cycle=%0d got=%h want=%h", i, obsVec(), expVec());
      end
    end
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
    stepCycle();
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    int bad = 0;
    doReset();
    req_a = 1'b1; req_b = 1'b1; lock = 1'b1;
    repeat (2 * MAX_HOLD_DEF + 2) begin
      stepCycle();
      if (gnt_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL lock_hold bad_cycles=%0d want 0", bad);
    end
    lock = 1'b0;
    stepCycle();
    checks++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_release got gnt_a=%b gnt_b=%b want 0 1", gnt_a, gnt_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    stepCycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_dual_rr();
    test_release();
    test_sole_b();
    test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
